gray_luma_core: RTL
===================

// Module: gray_luma_core
// PURPOSE
// - Streaming RGB-to-grayscale algorithm core, between the VIP flow-control wrapper's decoder side (stall/read) and encoder side (stall/write).
// - Latches each control packet, forwards it to the encoder with a send/busy handshake, then converts width*height pixels to 8-bit luma.
// - Fixed 2-cycle datapath pipeline with full backpressure.
// PARAMETERS
// - BITS_PER_SYMBOL   8   bits per colour plane and per output luma sample
// - SYMBOLS_PER_BEAT  3   colour planes per input beat: [23:16]=R, [15:8]=G, [7:0]=B
// - COEF_R / COEF_G / COEF_B   77 / 150 / 29   luma weights; must sum to 256
// PORTS
// - clk  in  1  system clock
// - rst  in  1  synchronous, active-high reset
// - stall_in  in  1  high = no active-video beat is available
// - read  out  1  consume data_in this cycle
// - data_in  in  24  RGB beat
// - end_of_video  in  1  sideband flag qualified by read; marks the last beat of a frame
// - width_in / height_in  in  16 / 16  decoder frame size
// - interlaced_in  in  4  decoder interlace nibble
// - vip_ctrl_valid  in  1  new control packet on width_in/height_in/interlaced_in
// - stall_out  in  1  high = encoder cannot accept a pixel
// - write  out  1  data_out is valid and accepted this cycle
// - data_out  out  8  luma sample
// - width_out / height_out  out  16 / 16  registered frame size sent to the encoder
// - interlaced_out  out  4  registered interlace nibble
// - vip_ctrl_send  out  1  one-cycle request to emit a control packet
// - vip_ctrl_busy  in  1  encoder is still busy with the previous control packet
// - end_of_video_out  out  1  qualified by write; marks the last luma sample of a frame
// BEHAVIOUR
// - Reset: all outputs 0, FSM in S_IDLE, pipeline valids cleared, pixel counter 0. In-flight pixels are dropped.
// - FSM states and transitions:
//   - S_IDLE: when vip_ctrl_valid=1, latch width/height/interlaced into *_out and go to S_SEND.
//   - S_SEND: while vip_ctrl_busy=1, hold vip_ctrl_send=0. On the first cycle with busy=0, pulse vip_ctrl_send=1 for exactly 1 cycle. Then go to S_PIX, or back to S_IDLE if width or height is 0.
//   - S_PIX: accept pixels until count == width*height (32-bit product). Then go to S_DRAIN.
//   - S_DRAIN: wait until both pipeline stages are empty, then go to S_IDLE.
//   - vip_ctrl_valid is ignored outside S_IDLE.
// - Pipeline handshake:
//   - adv = ~(v2 & stall_out)
//   - read = (state==S_PIX) & ~stall_in & adv & (count < total)
//   - write = v2 & ~stall_out
//   - Latency is 2 cycles from read to write.
//   - While stall_out is held, stages hold their contents and data_out stays stable. No pixel is lost or duplicated.
// - Arithmetic:
//   - Stage 1 registers the three 16-bit products.
//   - Stage 2 computes Y = (pR + pG + pB + 128) >> 8 in 17 bits. The maximum result is 255, so no saturation is needed.
// - end_of_video travels with its pixel through both stages.
//   - end_of_video_out = write & eov2.
//   - An early end_of_video (count < total) moves the FSM to S_DRAIN.
// - Simultaneous events:
//   - Stage-2 write and a new read in the same cycle are both permitted.
//   - vip_ctrl_valid arriving in the same cycle the FSM enters S_IDLE is taken the next cycle.
// STRUCTURE
// - Shared package gray_pkg: COEF_R/G/B, the rounding constant 128, the FSM state encoding (S_IDLE, S_SEND, S_PIX, S_DRAIN), and the RGB symbol-slice localparams.
// - Sub-module gray_luma_pipe holds the 2-stage multiply/sum datapath with valid, eov and enable. The FSM, counter and control registers stay in gray_luma_core.
// TESTING
// 1. Control packet 4x2 with busy=0 -> send is high for 1 cycle with width_out=4 and height_out=2. Then 8 beats produce exactly 8 writes, and the FSM returns to S_IDLE.
// 2. Conversion values:
//    - RGB (255,255,255) -> 255
//    - RGB (255,0,0) -> 77
//    - RGB (0,255,0) -> 149
//    - RGB (0,0,255) -> 29
//    - RGB (0,0,0) -> 0
//    - Each result appears 2 cycles after its read.
// 3. Pipeline full, then stall_out=1 for 5 cycles -> read=0, write=0 and data_out is stable. After release, the remaining pixels come out in order with no gaps or duplicates.
// 4. vip_ctrl_busy=1 for 3 cycles in S_SEND -> send stays 0 during those cycles. It pulses once on the cycle after busy falls, and no pixel is read before that pulse.
// 5. rst asserted after 3 pixels of a 4x4 frame -> next cycle write=0, send=0 and the FSM is in S_IDLE. A fresh 2x2 frame then converts correctly.
// 6. end_of_video on the last beat of a 2x2 frame -> end_of_video_out=1 on that pixel's write only. A 0x4 control packet sends, then returns to S_IDLE with no reads.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the RGB-to-luma core.
// Contents: luma weights, rounding constant, RGB symbol slice positions,
// and the control FSM state encoding.
package gray_pkg;

    localparam int BITS_PER_SYMBOL  = 8;
    localparam int SYMBOLS_PER_BEAT = 3;
    localparam int BEAT_W           = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

    // Luma weights (BT.601 scaled by 256). They must sum to 256 so that
    // full-scale white maps to exactly 255 and no saturation is needed.
    localparam logic [7:0] COEF_R = 8'd77;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd29;

    // Half an LSB of the >>8 result, for round-to-nearest.
    localparam logic [16:0] ROUND = 17'd128;

    // Symbol positions inside one input beat: [23:16]=R, [15:8]=G, [7:0]=B.
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_PIX   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/gray_luma_pipe.sv
// Two-stage RGB-to-luma datapath.
// Stage 1 registers the three weighted products, stage 2 registers the
// rounded sum. Both stages move only when en is high, so a stalled
// downstream freezes the whole pipe and luma stays stable.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   en          advance both stages this cycle
//   load        a new beat is consumed this cycle (only honoured with en)
//   rgb         input beat, R/G/B symbols
//   load_eov    end-of-frame flag belonging to the beat on rgb
//   valid1/2    stage occupancy
//   eov2        end-of-frame flag of the sample held in stage 2
//   luma        8-bit luma of the sample held in stage 2
module gray_luma_pipe
    import gray_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [BEAT_W-1:0] rgb,
    input  logic              load_eov,
    output logic              valid1,
    output logic              valid2,
    output logic              eov2,
    output logic [7:0]        luma
);

    logic [15:0] prod_r;
    logic [15:0] prod_g;
    logic [15:0] prod_b;
    logic        eov1;
    logic [16:0] sum;

    // 17 bits hold 255*256 + 128; the shifted result never exceeds 255.
    always_comb begin
        sum = {1'b0, prod_r} + {1'b0, prod_g} + {1'b0, prod_b} + ROUND;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid1 <= 1'b0;
            valid2 <= 1'b0;
            eov1   <= 1'b0;
            eov2   <= 1'b0;
            prod_r <= '0;
            prod_g <= '0;
            prod_b <= '0;
            luma   <= '0;
        end else if (en) begin
            valid1 <= load;
            eov1   <= load & load_eov;
            if (load) begin
                prod_r <= {8'd0, rgb[R_LSB +: BITS_PER_SYMBOL]} * {8'd0, COEF_R};
                prod_g <= {8'd0, rgb[G_LSB +: BITS_PER_SYMBOL]} * {8'd0, COEF_G};
                prod_b <= {8'd0, rgb[B_LSB +: BITS_PER_SYMBOL]} * {8'd0, COEF_B};
            end
            valid2 <= valid1;
            eov2   <= eov1;
            // Only overwrite on a real sample so data_out holds its last value.
            if (valid1) begin
                luma <= 8'(sum >> 8);
            end
        end
    end

endmodule

// File: rtl/gray_luma_core.sv
// Streaming RGB-to-grayscale core sitting between a VIP decoder
// (stall_in/read) and encoder (stall_out/write).
// Latches each control packet, forwards it with a send/busy handshake,
// then converts width*height pixels through a 2-cycle pipeline.
// Handshake: a beat moves from decoder to core when read=1 (core has room,
// decoder not stalled, frame not complete); a luma sample moves to the
// encoder when write=1 (stage 2 valid and encoder not stalled). A held
// stall_out freezes both stages, so nothing is lost or duplicated.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall_in, read, data_in       decoder side pixel handshake
//   end_of_video                  last-beat flag, qualified by read
//   width_in/height_in/interlaced_in, vip_ctrl_valid   decoder control packet
//   stall_out, write, data_out    encoder side pixel handshake
//   end_of_video_out              last-sample flag, qualified by write
//   width_out/height_out/interlaced_out  latched control packet
//   vip_ctrl_send, vip_ctrl_busy  encoder control handshake
//   fsm_state                     current FSM state (debug)
module gray_luma_core
    import gray_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    output logic              read,
    input  logic [BEAT_W-1:0] data_in,
    input  logic              end_of_video,
    input  logic [15:0]       width_in,
    input  logic [15:0]       height_in,
    input  logic [3:0]        interlaced_in,
    input  logic              vip_ctrl_valid,
    input  logic              stall_out,
    output logic              write,
    output logic [7:0]        data_out,
    output logic [15:0]       width_out,
    output logic [15:0]       height_out,
    output logic [3:0]        interlaced_out,
    output logic              vip_ctrl_send,
    input  logic              vip_ctrl_busy,
    output logic              end_of_video_out,
    output state_t            fsm_state
);

    state_t      state;
    logic [31:0] count;
    logic [31:0] total;
    logic        adv;
    logic        valid1;
    logic        valid2;
    logic        eov2;

    assign total = {16'd0, width_out} * {16'd0, height_out};

    // The pipe can move unless stage 2 is full and the encoder is stalled.
    assign adv              = ~(valid2 & stall_out);
    assign read             = (state == S_PIX) & ~stall_in & adv & (count < total);
    assign write            = valid2 & ~stall_out;
    assign end_of_video_out = write & eov2;
    assign fsm_state        = state;

    gray_luma_pipe u_pipe (
        .clk      (clk),
        .rst      (rst),
        .en       (adv),
        .load     (read),
        .rgb      (data_in),
        .load_eov (end_of_video),
        .valid1   (valid1),
        .valid2   (valid2),
        .eov2     (eov2),
        .luma     (data_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            count          <= '0;
            width_out      <= '0;
            height_out     <= '0;
            interlaced_out <= '0;
            vip_ctrl_send  <= 1'b0;
        end else begin
            vip_ctrl_send <= 1'b0;
            if (read) begin
                count <= count + 32'd1;
            end
            case (state)
                S_IDLE: begin
                    if (vip_ctrl_valid) begin
                        width_out      <= width_in;
                        height_out     <= height_in;
                        interlaced_out <= interlaced_in;
                        count          <= '0;
                        state          <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!vip_ctrl_busy) begin
                        vip_ctrl_send <= 1'b1;
                        // An empty frame has no pixels to wait for.
                        if (width_out == 16'd0 || height_out == 16'd0) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_PIX;
                        end
                    end
                end
                S_PIX: begin
                    // An end_of_video beat closes the frame early as well.
                    if (count == total || (read && end_of_video)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!valid1 && !valid2) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
